// File: rtl/reg_bank_sel_pkg.sv
// Shared constants, address-width helper and read-source select for the register bank.
package reg_bank_sel_pkg;

  localparam int unsigned DefW     = 4;
  localparam int unsigned DefDepth = 4;

  function automatic int unsigned calc_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef enum logic [1:0] {
    RS_NONE,
    RS_READ,
    RS_SCAN
  } rd_src_e;

endpackage

// File: rtl/reg_bank_rdmux.sv
// DEPTH:1 read mux returning the post-update value of the selected entry
// (write bypass first, then rotate correction, then stored value).
module reg_bank_rdmux
  import reg_bank_sel_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = calc_aw(DEPTH)
) (
  input  logic [DEPTH*W-1:0] entries_i,
  input  logic [AW-1:0]      idx_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [W-1:0]       wdata_i,
  input  logic               rot_i,
  output logic [W-1:0]       data_o
);

  logic [AW-1:0] src_idx;

  always_comb begin
    // After a rotate, entry k holds what entry k-1 held before the edge.
    src_idx = rot_i ? idx_i - 1'b1 : idx_i;
    data_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (AW'(i) == src_idx) begin
        data_o = entries_i[i*W +: W];
      end
    end
    if (we_i && (waddr_i == idx_i)) begin
      data_o = wdata_i;
    end
  end

endmodule

// File: rtl/reg_bank_sel.sv
// Parametrised register bank with per-entry write, rotate, registered read port
// with write bypass, and an auto-scan mode that streams every entry out in order.
module reg_bank_sel
  import reg_bank_sel_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = calc_aw(DEPTH)
) (
  input  logic          ck,
  input  logic          res,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          rot,
  input  logic          rd_req,
  input  logic [AW-1:0] raddr,
  input  logic          scan_en,
  output logic [W-1:0]  b,
  output logic          b_valid,
  output logic [AW-1:0] b_idx
);

  logic [W-1:0]       mem_q [DEPTH];
  logic [W-1:0]       mem_d [DEPTH];
  logic [DEPTH*W-1:0] mem_flat;

  logic [AW-1:0] scan_ptr_q, scan_ptr_d;
  logic          scan_en_q;
  logic [AW-1:0] ptr_eff;
  logic [AW-1:0] sel_idx;
  rd_src_e       rd_src;

  logic [W-1:0]  b_q, b_d;
  logic          b_valid_q, b_valid_d;
  logic [AW-1:0] b_idx_q, b_idx_d;
  logic [W-1:0]  rd_data;

  always_comb begin
    // A fresh scan_en assertion always starts the stream from entry 0.
    ptr_eff = (scan_en && !scan_en_q) ? '0 : scan_ptr_q;
    if (scan_en) begin
      rd_src = RS_SCAN;
    end else if (rd_req) begin
      rd_src = RS_READ;
    end else begin
      rd_src = RS_NONE;
    end
    sel_idx = (rd_src == RS_SCAN) ? ptr_eff : raddr;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_flat[i*W +: W] = mem_q[i];
      mem_d[i] = rot ? mem_q[AW'(i + DEPTH - 1)] : mem_q[i];
      if (we && (waddr == AW'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  reg_bank_rdmux #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_rdmux (
    .entries_i (mem_flat),
    .idx_i     (sel_idx),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .rot_i     (rot),
    .data_o    (rd_data)
  );

  always_comb begin
    b_d        = b_q;
    b_idx_d    = b_idx_q;
    b_valid_d  = 1'b0;
    scan_ptr_d = scan_ptr_q;
    if (rd_src != RS_NONE) begin
      b_d       = rd_data;
      b_idx_d   = sel_idx;
      b_valid_d = 1'b1;
    end
    if (rd_src == RS_SCAN) begin
      scan_ptr_d = ptr_eff + 1'b1;
    end
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      scan_ptr_q <= '0;
      scan_en_q  <= 1'b0;
      b_q        <= '0;
      b_valid_q  <= 1'b0;
      b_idx_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      scan_ptr_q <= scan_ptr_d;
      scan_en_q  <= scan_en;
      b_q        <= b_d;
      b_valid_q  <= b_valid_d;
      b_idx_q    <= b_idx_d;
    end
  end

  assign b       = b_q;
  assign b_valid = b_valid_q;
  assign b_idx   = b_idx_q;

endmodule

// File: tb/tb_reg_bank_sel.sv
// Drives a 4x4 and an 8x8 instance with identical stimulus and checks both
// against an array-based model of the bank.
module tb_reg_bank_sel;

  logic       ck;
  logic       res;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       rot;
  logic       rd_req;
  logic [2:0] raddr;
  logic       scan_en;

  logic [3:0] b_a;
  logic       bv_a;
  logic [1:0] bi_a;
  logic [7:0] b_b;
  logic       bv_b;
  logic [2:0] bi_b;
  logic [18:0] obs;

  int total;
  int bad;

  // Model state, index 0 = 4x4 instance, index 1 = 8x8 instance.
  logic [7:0] m_mem [2][8];
  logic [7:0] m_b [2];
  logic       m_bv [2];
  logic [2:0] m_bi [2];
  logic [2:0] m_ptr [2];
  logic       m_sprev [2];

  reg_bank_sel #(.W(4), .DEPTH(4)) dut_a (
    .ck      (ck),
    .res     (res),
    .we      (we),
    .waddr   (waddr[1:0]),
    .wdata   (wdata[3:0]),
    .rot     (rot),
    .rd_req  (rd_req),
    .raddr   (raddr[1:0]),
    .scan_en (scan_en),
    .b       (b_a),
    .b_valid (bv_a),
    .b_idx   (bi_a)
  );

  reg_bank_sel #(.W(8), .DEPTH(8)) dut_b (
    .ck      (ck),
    .res     (res),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rot     (rot),
    .rd_req  (rd_req),
    .raddr   (raddr),
    .scan_en (scan_en),
    .b       (b_b),
    .b_valid (bv_b),
    .b_idx   (bi_b)
  );

  assign obs = {b_a, bv_a, bi_a, b_b, bv_b, bi_b};

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 8; i++) m_mem[n][i] = 8'h00;
      m_b[n] = 8'h00; m_bv[n] = 1'b0; m_bi[n] = 3'd0; m_ptr[n] = 3'd0; m_sprev[n] = 1'b0;
    end
  endtask

  // One clock of the bank: build the post-edge array, then read from it.
  task automatic model_step();
    int d;
    int k;
    logic [7:0] wm;
    logic [7:0] nxt [8];
    for (int n = 0; n < 2; n++) begin
      d  = (n == 1) ? 8 : 4;
      wm = (n == 1) ? 8'hFF : 8'h0F;
      for (int i = 0; i < 8; i++) nxt[i] = 8'h00;
      for (int i = 0; i < d; i++) nxt[i] = rot ? m_mem[n][(i + d - 1) % d] : m_mem[n][i];
      if (we) nxt[int'(waddr) % d] = wdata & wm;
      k = -1;
      if (scan_en) begin
        k = m_sprev[n] ? int'(m_ptr[n]) : 0;
        m_ptr[n] = 3'((k + 1) % d);
      end else if (rd_req) begin
        k = int'(raddr) % d;
      end
      if (k >= 0) begin
        m_b[n] = nxt[k]; m_bv[n] = 1'b1; m_bi[n] = 3'(k);
      end else begin
        m_bv[n] = 1'b0;
      end
      m_sprev[n] = scan_en;
      for (int i = 0; i < 8; i++) m_mem[n][i] = nxt[i];
    end
  endtask

  function automatic logic [18:0] model_vec();
    return {m_b[0][3:0], m_bv[0], m_bi[0][1:0], m_b[1], m_bv[1], m_bi[1]};
  endfunction

  task automatic idle_inputs();
    we = 1'b0; waddr = 3'd0; wdata = 8'h00; rot = 1'b0;
    rd_req = 1'b0; raddr = 3'd0; scan_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge ck);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs(); we = 1'b1; waddr = 3'd2; wdata = 8'h07;
    tick();
    idle_inputs(); rd_req = 1'b1; raddr = 3'd2;
    tick();
    total++;
    if (obs !== model_vec()) begin
      bad++; $display("FAIL reset_preload got=%h want=%h", obs, model_vec());
    end
    #2 res = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 19'h0) begin
      bad++; $display("FAIL reset_immediate got=%h want=%h", obs, 19'h0);
    end
    @(negedge ck) res = 1'b1;
    rd_req = 1'b1; raddr = 3'd2;
    tick();
    total++;
    if (obs !== {4'h0, 1'b1, 2'd2, 8'h00, 1'b1, 3'd2}) begin
      bad++; $display("FAIL reset_read got=%h want=%h", obs, {4'h0, 1'b1, 2'd2, 8'h00, 1'b1, 3'd2});
    end
    idle_inputs();
    tick();
    total++;
    if (obs !== {4'h0, 1'b0, 2'd2, 8'h00, 1'b0, 3'd2}) begin
      bad++; $display("FAIL reset_read_drop got=%h want=%h", obs, {4'h0, 1'b0, 2'd2, 8'h00, 1'b0, 3'd2});
    end
  endtask

  task automatic test_write_read();
    idle_inputs(); we = 1'b1; waddr = 3'd1; wdata = 8'h0A;
    tick();
    total++;
    if (obs !== model_vec()) begin
      bad++; $display("FAIL wr_idle got=%h want=%h", obs, model_vec());
    end
    idle_inputs(); rd_req = 1'b1; raddr = 3'd1;
    tick();
    total++;
    if (obs !== {4'hA, 1'b1, 2'd1, 8'h0A, 1'b1, 3'd1}) begin
      bad++; $display("FAIL wr_read got=%h want=%h", obs, {4'hA, 1'b1, 2'd1, 8'h0A, 1'b1, 3'd1});
    end
    idle_inputs(); we = 1'b1; waddr = 3'd3; wdata = 8'h05; rd_req = 1'b1; raddr = 3'd3;
    tick();
    total++;
    if (obs !== {4'h5, 1'b1, 2'd3, 8'h05, 1'b1, 3'd3}) begin
      bad++; $display("FAIL wr_bypass got=%h want=%h", obs, {4'h5, 1'b1, 2'd3, 8'h05, 1'b1, 3'd3});
    end
    idle_inputs();
  endtask

  task automatic load_1234();
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); we = 1'b1; waddr = 3'(i); wdata = 8'(i + 1);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_rotate_write();
    logic [3:0] ev;
    load_1234();
    rot = 1'b1; we = 1'b1; waddr = 3'd0; wdata = 8'h0F;
    tick();
    idle_inputs(); scan_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 4) begin
        ev = (i == 0) ? 4'hF : 4'(i);
        total++;
        if (obs !== {ev, 1'b1, 2'(i), 4'h0, ev, 1'b1, 3'(i)}) begin
          bad++; $display("FAIL rot_scan%0d got=%h want=%h", i, obs, {ev, 1'b1, 2'(i), 4'h0, ev, 1'b1, 3'(i)});
        end
      end
      total++;
      if (obs !== model_vec()) begin
        bad++; $display("FAIL rot_model%0d got=%h want=%h", i, obs, model_vec());
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_scan_wrap();
    load_1234();
    for (int run = 0; run < 2; run++) begin
      scan_en = 1'b1;
      for (int i = 0; i < ((run == 0) ? 10 : 3); i++) begin
        tick();
        total++;
        if ({b_a, bv_a, bi_a} !== {4'((i % 4) + 1), 1'b1, 2'(i % 4)}) begin
          bad++; $display("FAIL scan_a r%0d c%0d got=%h want=%h", run, i, {b_a, bv_a, bi_a},
                          {4'((i % 4) + 1), 1'b1, 2'(i % 4)});
        end
        total++;
        if (obs !== model_vec()) begin
          bad++; $display("FAIL scan_model r%0d c%0d got=%h want=%h", run, i, obs, model_vec());
        end
      end
      scan_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tick();
        total++;
        if (obs !== model_vec()) begin
          bad++; $display("FAIL scan_gap r%0d c%0d got=%h want=%h", run, i, obs, model_vec());
        end
      end
    end
  endtask

  task automatic test_priority_reset();
    idle_inputs(); scan_en = 1'b1; rd_req = 1'b1; raddr = 3'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ((bi_a !== 2'(i % 4)) || (bi_b !== 3'(i)) || (obs !== model_vec())) begin
        bad++; $display("FAIL prio%0d got=%h want=%h", i, obs, model_vec());
      end
    end
    #2 res = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 19'h0) begin
      bad++; $display("FAIL prio_reset got=%h want=%h", obs, 19'h0);
    end
    @(negedge ck) res = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== {4'h0, 1'b1, 2'(i), 8'h00, 1'b1, 3'(i)}) begin
        bad++; $display("FAIL prio_restart%0d got=%h want=%h", i, obs,
                        {4'h0, 1'b1, 2'(i), 8'h00, 1'b1, 3'(i)});
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 8'($urandom_range(0, 255));
      rot     = ($urandom_range(0, 3) == 0);
      rd_req  = 1'($urandom_range(0, 1));
      raddr   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) scan_en = ~scan_en;
      tick();
      total++;
      if (obs !== model_vec()) begin
        bad++; $display("FAIL rand%0d got=%h want=%h", i, obs, model_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    res = 1'b0;
    model_reset();
    @(negedge ck) res = 1'b1;
    test_reset();
    test_write_read();
    test_rotate_write();
    test_scan_wrap();
    test_priority_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_sel.md
Name: reg_bank_sel

Overview:
- Parametrised successor to the fixed four-entry, 4-bit register/select bank: DEPTH entries of W bits, each with its own write enable.
- Adds a registered read port with a valid strobe and write-to-read bypass.
- Adds a rotate operation that shifts all entries by one position.
- Adds an auto-scan mode that streams every entry out in order.
- Sits between switch/input capture logic and display/output logic in the small-project datapath.

Parameters:
- W, 4, data width of each entry and of the output.
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- res  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  W  write data.
- rot  input  1  rotate strobe; applied in every cycle it is high.
- rd_req  input  1  single-read request.
- raddr  input  AW  single-read address.
- scan_en  input  1  auto-scan enable.
- b  output  W  registered read data.
- b_valid  output  1  b holds new data this cycle.
- b_idx  output  AW  index of the entry currently on b.

Behaviour:
- Reset:
  - res low clears immediately: all entries, b, b_valid, b_idx, the scan pointer and the internal scan_en delay register go to 0.
  - Reset mid-scan or mid-read drops b_valid in the same instant; no completion after release.
- Storage update (rising ck), evaluated in this order:
  - Rotate: if rot, entry[i] <= entry[i-1] for i>0, and entry[0] <= entry[DEPTH-1].
  - Write: if we, entry[waddr] <= wdata.
  - When we and rot are high in the same cycle, the write wins at waddr. Every other entry takes its rotated value.
- Read port:
  - Latency is 1 cycle. Request in cycle N gives b/b_valid/b_idx in cycle N+1.
  - b_valid is high only in cycles following a request or scan step. Otherwise b_valid is 0 and b and b_idx hold their last values.
- Read source, by priority:
  - Scan active (scan_en=1): source index = scan pointer; rd_req is ignored.
  - Otherwise rd_req=1: source index = raddr.
  - Otherwise no read.
- Read data rule for a selected index k is the post-update value of entry k:
  - If we and waddr==k, return wdata (bypass).
  - Else if rot, return the pre-edge entry[(k-1) mod DEPTH].
  - Else return entry[k].
- Scan mode:
  - Rising edge of scan_en (scan_en=1 while delayed scan_en=0): scan pointer treated as 0 this cycle.
  - Each scan cycle reads the pointer's entry, then pointer <= pointer+1, wrapping from DEPTH-1 to 0.
  - The scan streams continuously; b_valid stays high every cycle while scan_en=1.
  - scan_en low: pointer holds its value, but the next rising edge restarts the scan from 0.
- All arithmetic is unsigned.
  - Pointer wrap uses natural AW-bit overflow, which is valid because DEPTH is a power of two.
  - No X outputs in any state; an out-of-range index is impossible by construction.

Decomposition:
- Shared package holds:
  - default W and DEPTH constants;
  - a function computing AW;
  - an enum for the read-source select: RS_NONE, RS_READ, RS_SCAN.
- One natural sub-module: reg_bank_rdmux, a combinational DEPTH:1 W-bit mux.
  - Inputs are the flattened entries plus the bypass/rotate correction.
  - It generalises the fixed four-way select.
- Storage, rotate, write, scan pointer and output registers stay in the top.

Test Plan:
- Reset/basic read:
  - Stimulus: assert res low mid-cycle, release, then rd_req raddr=2.
  - Response: b=0, b_valid=0 immediately on reset; after the read, b=0, b_valid=1, b_idx=2 one cycle later, then b_valid=0.
- Write then read, plus bypass:
  - Stimulus: write 0xA to entry 1; next cycle rd_req raddr=1. Then we waddr=3 wdata=0x5 together with rd_req raddr=3 in the same cycle.
  - Response: the first read gives b=0xA. The combined cycle gives b=0x5 next cycle.
- Rotate with concurrent write:
  - Stimulus: entries {1,2,3,4}; rot=1, we=1, waddr=0, wdata=0xF for one cycle.
  - Response: entries become {F,1,2,3}. A later scan outputs F,1,2,3.
- Scan wrap and restart:
  - Stimulus: entries {1,2,3,4}; scan_en high for 6 cycles, low for 2, high again.
  - Response: first run gives b = 1,2,3,4,1,2 with b_idx 0,1,2,3,0,1 and b_valid continuous. After the gap, output restarts at 1 (b_idx=0).
- Priority and reset mid-scan:
  - Stimulus: scan_en=1 with rd_req=1, raddr=3.
  - Response: raddr is ignored and the scan order is kept.
  - Stimulus: pulse res low during the scan.
  - Response: all entries 0, b_valid=0 at once; after release with scan_en still 1, the scan restarts at index 0 with b=0.
- Parameter sweep:
  - Stimulus: rerun all scenarios above with W=8, DEPTH=8.
  - Response: scan wraps after index 7, and 8-bit data passes through unchanged.
